packet_assembler: RTL and testbench

PACKET_ASSEMBLER -- requirements
Module: packet_assembler

---
 rtl/packet_assembler_pkg.sv | 14 +
 rtl/packet_assembler_shreg.sv | 32 +++
 rtl/packet_assembler.sv | 104 ++++++++++
 tb/tb_packet_assembler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/packet_assembler_pkg.sv
// Shared types and helpers for the packet assembler: FSM state encoding and
// the ceil-divide used to size the piece shift register.
package packet_assembler_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/packet_assembler_shreg.sv
// Piece shift register: each enabled cycle shifts the new piece into the low
// end while older pieces move up one slot.
module packet_assembler_shreg
   import packet_assembler_pkg::*;
#(
   parameter int nbits_in = 8,
   parameter int num_regs = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [nbits_in-1:0]          in,
   output logic [num_regs*nbits_in-1:0] out
);

   generate
      if (num_regs == 1) begin : g_single
         always_ff @(posedge clk or posedge reset) begin
            if (reset)   out <= '0;
            else if (en) out <= in;
         end
      end else begin : g_shift
         // NOTE: the data register is reset too, because the assembled output
         // must read as zero straight out of reset, not just be marked invalid.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)   out <= '0;
            else if (en) out <= {out[num_regs*nbits_in-nbits_in-1:0], in};
         end
      end
   endgenerate

endmodule

// File: rtl/packet_assembler.sv
// Assembles num_regs narrow pieces (first piece most significant) into one
// wide packet. Optional macro PACKET_ASSEMBLER_FLOWTHRU_EN lets a new packet
// start in the same cycle the finished one is taken.
module packet_assembler
   import packet_assembler_pkg::*;
#(
   parameter int nbits_in  = 8,
   parameter int nbits_out = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_val,
   output logic                 req_rdy,
   input  logic [nbits_in-1:0]  req_msg,
   output logic                 resp_val,
   input  logic                 resp_rdy,
   output logic [nbits_out-1:0] resp_msg
);

   localparam int num_regs = ceil_div(nbits_out, nbits_in);
   localparam int cnt_bits = (num_regs > 1) ? $clog2(num_regs) : 1;

   typedef logic [cnt_bits:0] cnt_t;
   localparam cnt_t last_cnt = cnt_t'(num_regs - 1);

   state_t state, state_nx;
   cnt_t   cnt, cnt_nx;
   logic   accept;
   logic [num_regs*nbits_in-1:0] shreg_out;
   logic   unused_hi;

   assign accept = req_val & req_rdy;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= COLLECT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      req_rdy  = 1'b0;
      resp_val = 1'b0;
      case (state)
         COLLECT: begin
            req_rdy = 1'b1;
            if (req_val) begin
               if (cnt == last_cnt) begin
                  cnt_nx   = '0;
                  state_nx = DONE;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
         end
         DONE: begin
            resp_val = 1'b1;
`ifdef PACKET_ASSEMBLER_FLOWTHRU_EN
            req_rdy = resp_rdy;
            if (resp_rdy) begin
               // A piece taken here is the first piece of the next packet.
               if (req_val && num_regs > 1) begin
                  cnt_nx   = cnt_t'(1);
                  state_nx = COLLECT;
               end else if (req_val) begin
                  cnt_nx   = '0;
                  state_nx = DONE;
               end else begin
                  state_nx = COLLECT;
               end
            end
`else
            if (resp_rdy) state_nx = COLLECT;
`endif
         end
         default: state_nx = COLLECT;
      endcase
   end

   packet_assembler_shreg #(
      .nbits_in (nbits_in),
      .num_regs (num_regs)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .in    (req_msg),
      .out   (shreg_out)
   );

   // Bits of the first piece above nbits_out are shifted in but never seen.
   assign resp_msg  = shreg_out[nbits_out-1:0];
   assign unused_hi = ^shreg_out;

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: an 8->16 instance and an 8->12
// instance, each with its own expected-packet queue and output monitor.
module tb_packet_assembler;

`ifdef PACKET_ASSEMBLER_FLOWTHRU_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
   logic [7:0]  a_req_msg;
   logic [15:0] a_resp_msg;
   logic        b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
   logic [7:0]  b_req_msg;
   logic [11:0] b_resp_msg;

   logic [15:0] a_exp[$];
   logic [11:0] b_exp[$];
   int          a_times[$];
   bit          rt_done;
   logic [15:0] rt_pkts[8];

   packet_assembler #(.nbits_in(8), .nbits_out(16)) dut_a (
      .clk(clk), .reset(reset),
      .req_val(a_req_val), .req_rdy(a_req_rdy), .req_msg(a_req_msg),
      .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_msg(a_resp_msg)
   );

   packet_assembler #(.nbits_in(8), .nbits_out(12)) dut_b (
      .clk(clk), .reset(reset),
      .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
      .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Output monitors: pop the oldest expected packet on every transfer.
   always @(negedge clk) begin
      if (a_resp_val && a_resp_rdy) begin
         a_times.push_back(cyc);
         if (a_exp.size() == 0) check("a_unexpected_packet", 32'(a_resp_msg), 32'hFFFF_FFFF);
         else                   check("a_packet", 32'(a_resp_msg), 32'(a_exp.pop_front()));
      end
      if (b_resp_val && b_resp_rdy) begin
         if (b_exp.size() == 0) check("b_unexpected_packet", 32'(b_resp_msg), 32'hFFFF_FFFF);
         else                   check("b_packet", 32'(b_resp_msg), 32'(b_exp.pop_front()));
      end
   end

   // Offers a piece, samples readiness at the falling edge, returns just
   // after the accepting edge with junk on req_msg and req_val low.
   task automatic a_send(input logic [7:0] m);
      bit ok = 1'b0;
      a_req_val = 1'b1;
      a_req_msg = m;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = a_req_rdy;
         @(posedge clk);
         #1;
      end
      if (!ok) check("a_send_timeout", 32'(ok), 32'd1);
      a_req_val = 1'b0;
      a_req_msg = 8'($urandom);
   endtask

   task automatic b_send(input logic [7:0] m);
      bit ok = 1'b0;
      b_req_val = 1'b1;
      b_req_msg = m;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = b_req_rdy;
         @(posedge clk);
         #1;
      end
      if (!ok) check("b_send_timeout", 32'(ok), 32'd1);
      b_req_val = 1'b0;
      b_req_msg = 8'($urandom);
   endtask

   initial begin
      a_req_val = 1'b0; a_req_msg = '0; a_resp_rdy = 1'b1;
      b_req_val = 1'b0; b_req_msg = '0; b_resp_rdy = 1'b1;
      rt_done = 1'b0;

      // Reset state
      #2 reset = 1'b1;
      #1;
      check("rst_req_rdy", 32'(a_req_rdy), 32'd1);
      check("rst_resp_val", 32'(a_resp_val), 32'd0);
      check("rst_resp_msg", 32'(a_resp_msg), 32'd0);
      check("rst_b_resp_msg", 32'(b_resp_msg), 32'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;

      // Basic: 0xAB, 0xCD -> 0xABCD the cycle after the last piece, for one cycle
      a_exp.push_back(16'hABCD);
      a_send(8'hAB);
      a_send(8'hCD);
      check("basic_resp_val", 32'(a_resp_val), 32'd1);
      check("basic_resp_msg", 32'(a_resp_msg), 32'hABCD);
      @(posedge clk); #1;
      check("basic_one_cycle", 32'(a_resp_val), 32'd0);

      // Backpressure: hold for 5 cycles with a junk piece offered
      a_resp_rdy = 1'b0;
      a_exp.push_back(16'hABCD);
      a_send(8'hAB);
      a_send(8'hCD);
      a_req_val = 1'b1;
      a_req_msg = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         check("bp_resp_val", 32'(a_resp_val), 32'd1);
         check("bp_resp_msg", 32'(a_resp_msg), 32'hABCD);
         check("bp_req_rdy", 32'(a_req_rdy), 32'd0);
         @(posedge clk); #1;
      end
      a_req_val = 1'b0;
      a_resp_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_released", 32'(a_resp_val), 32'd0);
      check("bp_drained", 32'(a_exp.size()), 32'd0);

      // Uneven widths: 0x5A, 0xBC -> 0xABC
      b_exp.push_back(12'hABC);
      b_send(8'h5A);
      b_send(8'hBC);
      check("uneven_resp_msg", 32'(b_resp_msg), 32'hABC);
      @(posedge clk); #1;

      // Asynchronous reset while a finished packet is held
      a_resp_rdy = 1'b0;
      a_send(8'h77);
      a_send(8'h88);
      #3 reset = 1'b1;
      #1;
      check("async_rst_resp_val", 32'(a_resp_val), 32'd0);
      check("async_rst_req_rdy", 32'(a_req_rdy), 32'd1);
      check("async_rst_resp_msg", 32'(a_resp_msg), 32'd0);
      #2 reset = 1'b0;
      a_resp_rdy = 1'b1;
      @(posedge clk); #1;

      // Reset mid-packet discards the partial piece
      a_exp.push_back(16'h2233);
      a_send(8'h11);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_resp_msg", 32'(a_resp_msg), 32'd0);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      a_send(8'h22);
      a_send(8'h33);
      check("mid_rst_packet", 32'(a_resp_msg), 32'h2233);
      @(posedge clk); #1;

      // Throughput with continuous pieces and resp_rdy=1
      a_times.delete();
      for (int i = 0; i < 4; i++) a_exp.push_back({8'(2 * i + 1), 8'(2 * i + 2)});
      for (int i = 0; i < 4; i++) begin
         a_send(8'(2 * i + 1));
         a_send(8'(2 * i + 2));
      end
      repeat (3) @(posedge clk);
      #1;
      check("tput_count", 32'(a_times.size()), 32'd4);
      for (int i = 1; i < a_times.size(); i++)
         check("tput_gap", 32'(a_times[i] - a_times[i-1]), 32'(GAP));

      // Round trip: 16-bit packets split high byte first, random consumer stalls
      for (int i = 0; i < 8; i++) rt_pkts[i] = 16'($urandom);
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               a_exp.push_back(rt_pkts[i]);
               a_send(rt_pkts[i][15:8]);
               a_send(rt_pkts[i][7:0]);
            end
            rt_done = 1'b1;
         end
         begin
            while (!rt_done) begin
               @(posedge clk); #1;
               a_resp_rdy = 1'($urandom_range(0, 1));
            end
            a_resp_rdy = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check("rt_drained", 32'(a_exp.size()), 32'd0);
      check("b_drained", 32'(b_exp.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
